// File: rtl/exu_biu_arb.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// It keeps a single outstanding transaction and routes the response back to its owner.
module exu_biu_arb (
  input  logic        clk,
  input  logic        rst_n,
  // fetch requester
  input  logic        hs_if4bi_val,
  input  logic [31:0] i_if_adr,
  output logic        hs_bi4if_rdy,
  output logic        o_if_rsp_val,
  output logic [31:0] o_if_rdat,
  // load/store requester
  input  logic        hs_ls4bi_val,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ls_wdat,
  input  logic [3:0]  i_ls_wen,
  input  logic        i_ls_ren,
  output logic        hs_bi4ls_rdy,
  output logic        o_ls_rsp_val,
  output logic [31:0] o_ls_rdat,
  // memory port
  output logic        hs_bi4mm_val,
  input  logic        hs_mm4bi_rdy,
  output logic [31:0] o_mm_adr,
  output logic [31:0] o_mm_wdat,
  output logic [3:0]  o_mm_wen,
  output logic        o_mm_ren,
  input  logic        i_mm_rsp_val,
  input  logic [31:0] i_mm_rdat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  state_t      r_state;
  state_t      w_state_nxt;
  owner_t      r_owner;
  owner_t      r_last_grant;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [3:0]  r_wen;
  logic        r_ren;

  logic        w_grant_if;
  logic        w_grant_ls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_IF;
      r_last_grant <= OWN_LS;
      r_adr        <= 32'd0;
      r_wdat       <= 32'd0;
      r_wen        <= 4'd0;
      r_ren        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_if) begin
        r_owner      <= OWN_IF;
        r_last_grant <= OWN_IF;
        r_adr        <= i_if_adr;
        r_wdat       <= 32'd0;
        r_wen        <= 4'd0;
        r_ren        <= 1'b1;
      end else if (w_grant_ls) begin
        r_owner      <= OWN_LS;
        r_last_grant <= OWN_LS;
        r_adr        <= i_ls_adr;
        r_wdat       <= i_ls_wdat;
        r_wen        <= i_ls_wen;
        r_ren        <= i_ls_ren;
      end
    end
  end

  // Grants are gated by rst_n so every output is 0 while reset is held,
  // even if a requester keeps val asserted.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_if   = 1'b0;
    w_grant_ls   = 1'b0;
    hs_bi4if_rdy = 1'b0;
    hs_bi4ls_rdy = 1'b0;
    o_if_rsp_val = 1'b0;
    o_if_rdat    = 32'd0;
    o_ls_rsp_val = 1'b0;
    o_ls_rdat    = 32'd0;
    hs_bi4mm_val = 1'b0;
    o_mm_adr     = 32'd0;
    o_mm_wdat    = 32'd0;
    o_mm_wen     = 4'd0;
    o_mm_ren     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rst_n) begin
          if (hs_if4bi_val && (!hs_ls4bi_val || (r_last_grant == OWN_LS))) begin
            w_grant_if = 1'b1;
          end else if (hs_ls4bi_val) begin
            w_grant_ls = 1'b1;
          end
        end
        hs_bi4if_rdy = w_grant_if;
        hs_bi4ls_rdy = w_grant_ls;
        if (w_grant_if || w_grant_ls) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        hs_bi4mm_val = 1'b1;
        o_mm_adr     = r_adr;
        o_mm_wdat    = r_wdat;
        o_mm_wen     = r_wen;
        o_mm_ren     = r_ren;
        if (hs_mm4bi_rdy) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mm_rsp_val) begin
          if (r_owner == OWN_IF) begin
            o_if_rsp_val = 1'b1;
            o_if_rdat    = i_mm_rdat;
          end else begin
            o_ls_rsp_val = 1'b1;
            o_ls_rdat    = i_mm_rdat;
          end
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exu_biu_arb.sv
// Directed self-checking bench for exu_biu_arb.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_exu_biu_arb;

  logic        clk;
  logic        rst_n;
  logic        hs_if4bi_val;
  logic [31:0] i_if_adr;
  logic        hs_bi4if_rdy;
  logic        o_if_rsp_val;
  logic [31:0] o_if_rdat;
  logic        hs_ls4bi_val;
  logic [31:0] i_ls_adr;
  logic [31:0] i_ls_wdat;
  logic [3:0]  i_ls_wen;
  logic        i_ls_ren;
  logic        hs_bi4ls_rdy;
  logic        o_ls_rsp_val;
  logic [31:0] o_ls_rdat;
  logic        hs_bi4mm_val;
  logic        hs_mm4bi_rdy;
  logic [31:0] o_mm_adr;
  logic [31:0] o_mm_wdat;
  logic [3:0]  o_mm_wen;
  logic        o_mm_ren;
  logic        i_mm_rsp_val;
  logic [31:0] i_mm_rdat;

  int checks;
  int failures;

  exu_biu_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hs_if4bi_val (hs_if4bi_val),
    .i_if_adr     (i_if_adr),
    .hs_bi4if_rdy (hs_bi4if_rdy),
    .o_if_rsp_val (o_if_rsp_val),
    .o_if_rdat    (o_if_rdat),
    .hs_ls4bi_val (hs_ls4bi_val),
    .i_ls_adr     (i_ls_adr),
    .i_ls_wdat    (i_ls_wdat),
    .i_ls_wen     (i_ls_wen),
    .i_ls_ren     (i_ls_ren),
    .hs_bi4ls_rdy (hs_bi4ls_rdy),
    .o_ls_rsp_val (o_ls_rsp_val),
    .o_ls_rdat    (o_ls_rdat),
    .hs_bi4mm_val (hs_bi4mm_val),
    .hs_mm4bi_rdy (hs_mm4bi_rdy),
    .o_mm_adr     (o_mm_adr),
    .o_mm_wdat    (o_mm_wdat),
    .o_mm_wen     (o_mm_wen),
    .o_mm_ren     (o_mm_ren),
    .i_mm_rsp_val (i_mm_rsp_val),
    .i_mm_rdat    (i_mm_rdat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    hs_if4bi_val = 1'b1;
    hs_ls4bi_val = 1'b1;
    i_if_adr     = 32'h0000_0010;
    i_ls_adr     = 32'h0000_0020;
    i_ls_wdat    = 32'h0;
    i_ls_wen     = 4'h0;
    i_ls_ren     = 1'b1;
    hs_mm4bi_rdy = 1'b1;
    i_mm_rsp_val = 1'b1;
    i_mm_rdat    = 32'hFFFF_FFFF;
    #2;
    checks++; if (hs_bi4if_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_if_rdy got=%0h exp=0", hs_bi4if_rdy); end
    checks++; if (hs_bi4ls_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_ls_rdy got=%0h exp=0", hs_bi4ls_rdy); end
    checks++; if (hs_bi4mm_val !== 1'b0) begin failures++; $display("[TB] FAIL reset_mm_val got=%0h exp=0", hs_bi4mm_val); end
    checks++; if ({o_mm_adr, o_mm_wdat, o_mm_wen, o_mm_ren} !== 69'd0) begin failures++; $display("[TB] FAIL reset_mm_fields got=%0h exp=0", {o_mm_adr, o_mm_wdat, o_mm_wen, o_mm_ren}); end
    checks++; if ({o_if_rsp_val, o_ls_rsp_val, o_if_rdat, o_ls_rdat} !== 66'd0) begin failures++; $display("[TB] FAIL reset_rsp got=%0h exp=0", {o_if_rsp_val, o_ls_rsp_val, o_if_rdat, o_ls_rdat}); end
    hs_if4bi_val = 1'b0;
    hs_ls4bi_val = 1'b0;
    i_mm_rsp_val = 1'b0;
    i_mm_rdat    = 32'h0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_round_robin();
    logic exp_ls;
    hs_if4bi_val = 1'b1;
    hs_ls4bi_val = 1'b1;
    i_if_adr     = 32'h0000_00A0;
    i_ls_adr     = 32'h0000_00B0;
    i_ls_wdat    = 32'h0;
    i_ls_wen     = 4'h0;
    i_ls_ren     = 1'b1;
    hs_mm4bi_rdy = 1'b1;
    for (int t = 0; t < 6; t++) begin
      exp_ls = (t % 2) == 1;
      @(negedge clk);
      checks++; if ({hs_bi4if_rdy, hs_bi4ls_rdy} !== {~exp_ls, exp_ls}) begin failures++; $display("[TB] FAIL rr_grant t=%0d got=%b exp=%b", t, {hs_bi4if_rdy, hs_bi4ls_rdy}, {~exp_ls, exp_ls}); end
      cyc();
      @(negedge clk);
      checks++; if ({hs_bi4if_rdy, hs_bi4ls_rdy} !== 2'b00) begin failures++; $display("[TB] FAIL rr_rdy_req t=%0d got=%b exp=00", t, {hs_bi4if_rdy, hs_bi4ls_rdy}); end
      checks++; if (o_mm_adr !== (exp_ls ? 32'h0000_00B0 : 32'h0000_00A0)) begin failures++; $display("[TB] FAIL rr_adr t=%0d got=%0h exp=%0h", t, o_mm_adr, exp_ls ? 32'h0000_00B0 : 32'h0000_00A0); end
      cyc();
      i_mm_rsp_val = 1'b1;
      i_mm_rdat    = 32'h0000_1000 + t;
      @(negedge clk);
      checks++; if ({o_if_rsp_val, o_ls_rsp_val} !== {~exp_ls, exp_ls}) begin failures++; $display("[TB] FAIL rr_rsp t=%0d got=%b exp=%b", t, {o_if_rsp_val, o_ls_rsp_val}, {~exp_ls, exp_ls}); end
      checks++; if ({hs_bi4if_rdy, hs_bi4ls_rdy} !== 2'b00) begin failures++; $display("[TB] FAIL rr_rdy_wait t=%0d got=%b exp=00", t, {hs_bi4if_rdy, hs_bi4ls_rdy}); end
      cyc();
      i_mm_rsp_val = 1'b0;
    end
    hs_if4bi_val = 1'b0;
    hs_ls4bi_val = 1'b0;
    cyc();
  endtask

  task automatic test_single_fetch();
    hs_if4bi_val = 1'b1;
    i_if_adr     = 32'h0000_0100;
    hs_mm4bi_rdy = 1'b1;
    @(negedge clk);
    checks++; if (hs_bi4if_rdy !== 1'b1) begin failures++; $display("[TB] FAIL fetch_rdy got=%0h exp=1", hs_bi4if_rdy); end
    checks++; if (hs_bi4mm_val !== 1'b0) begin failures++; $display("[TB] FAIL fetch_mm_val_c0 got=%0h exp=0", hs_bi4mm_val); end
    cyc();
    hs_if4bi_val = 1'b0;
    i_if_adr     = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if (hs_bi4mm_val !== 1'b1) begin failures++; $display("[TB] FAIL fetch_mm_val got=%0h exp=1", hs_bi4mm_val); end
    checks++; if ({o_mm_adr, o_mm_wdat, o_mm_wen, o_mm_ren} !== {32'h100, 32'h0, 4'h0, 1'b1}) begin failures++; $display("[TB] FAIL fetch_mm_fields got=%0h/%0h/%0h/%0h exp=100/0/0/1", o_mm_adr, o_mm_wdat, o_mm_wen, o_mm_ren); end
    checks++; if (o_ls_rsp_val !== 1'b0) begin failures++; $display("[TB] FAIL fetch_ls_rsp_c1 got=%0h exp=0", o_ls_rsp_val); end
    cyc();
    i_mm_rsp_val = 1'b1;
    i_mm_rdat    = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (o_if_rsp_val !== 1'b1) begin failures++; $display("[TB] FAIL fetch_rsp_val got=%0h exp=1", o_if_rsp_val); end
    checks++; if (o_if_rdat !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL fetch_rdat got=%0h exp=deadbeef", o_if_rdat); end
    checks++; if ({o_ls_rsp_val, o_ls_rdat} !== 33'd0) begin failures++; $display("[TB] FAIL fetch_ls_rsp got=%0h exp=0", {o_ls_rsp_val, o_ls_rdat}); end
    cyc();
    i_mm_rsp_val = 1'b1;
    @(negedge clk);
    checks++; if ({o_if_rsp_val, o_if_rdat} !== 33'd0) begin failures++; $display("[TB] FAIL fetch_rsp_pulse got=%0h exp=0", {o_if_rsp_val, o_if_rdat}); end
    cyc();
    i_mm_rsp_val = 1'b0;
    i_mm_rdat    = 32'h0;
  endtask

  task automatic test_store();
    hs_ls4bi_val = 1'b1;
    i_ls_adr     = 32'h0000_2004;
    i_ls_wdat    = 32'h1234_5678;
    i_ls_wen     = 4'b0011;
    i_ls_ren     = 1'b0;
    hs_mm4bi_rdy = 1'b1;
    @(negedge clk);
    checks++; if ({hs_bi4if_rdy, hs_bi4ls_rdy} !== 2'b01) begin failures++; $display("[TB] FAIL store_rdy got=%b exp=01", {hs_bi4if_rdy, hs_bi4ls_rdy}); end
    cyc();
    hs_ls4bi_val = 1'b0;
    i_ls_adr     = 32'h0;
    i_ls_wdat    = 32'h0;
    i_ls_wen     = 4'h0;
    @(negedge clk);
    checks++; if ({hs_bi4mm_val, o_mm_adr, o_mm_wdat, o_mm_wen, o_mm_ren} !== {1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 1'b0}) begin failures++; $display("[TB] FAIL store_mm got=%0h/%0h/%0h/%0h/%0h exp=1/2004/12345678/3/0", hs_bi4mm_val, o_mm_adr, o_mm_wdat, o_mm_wen, o_mm_ren); end
    cyc();
    i_mm_rsp_val = 1'b1;
    i_mm_rdat    = 32'h0000_55AA;
    @(negedge clk);
    checks++; if ({o_if_rsp_val, o_ls_rsp_val} !== 2'b01) begin failures++; $display("[TB] FAIL store_rsp got=%b exp=01", {o_if_rsp_val, o_ls_rsp_val}); end
    checks++; if (o_ls_rdat !== 32'h0000_55AA) begin failures++; $display("[TB] FAIL store_rdat got=%0h exp=55aa", o_ls_rdat); end
    cyc();
    i_mm_rsp_val = 1'b0;
    i_mm_rdat    = 32'h0;
  endtask

  task automatic test_backpressure();
    hs_if4bi_val = 1'b1;
    i_if_adr     = 32'h0000_0300;
    hs_mm4bi_rdy = 1'b0;
    @(negedge clk);
    checks++; if (hs_bi4if_rdy !== 1'b1) begin failures++; $display("[TB] FAIL bp_grant got=%0h exp=1", hs_bi4if_rdy); end
    cyc();
    hs_if4bi_val = 1'b0;
    hs_ls4bi_val = 1'b1;
    i_ls_adr     = 32'h0000_0444;
    i_ls_ren     = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++; if ({hs_bi4mm_val, o_mm_adr, o_mm_wdat, o_mm_wen, o_mm_ren} !== {1'b1, 32'h300, 32'h0, 4'h0, 1'b1}) begin failures++; $display("[TB] FAIL bp_hold s=%0d got=%0h/%0h/%0h/%0h/%0h exp=1/300/0/0/1", s, hs_bi4mm_val, o_mm_adr, o_mm_wdat, o_mm_wen, o_mm_ren); end
      checks++; if ({hs_bi4if_rdy, hs_bi4ls_rdy} !== 2'b00) begin failures++; $display("[TB] FAIL bp_rdy s=%0d got=%b exp=00", s, {hs_bi4if_rdy, hs_bi4ls_rdy}); end
      cyc();
    end
    hs_mm4bi_rdy = 1'b1;
    hs_ls4bi_val = 1'b0;
    @(negedge clk);
    checks++; if ({hs_bi4mm_val, o_mm_adr} !== {1'b1, 32'h300}) begin failures++; $display("[TB] FAIL bp_release got=%0h/%0h exp=1/300", hs_bi4mm_val, o_mm_adr); end
    cyc();
    i_mm_rsp_val = 1'b1;
    i_mm_rdat    = 32'hCAFE_0300;
    @(negedge clk);
    checks++; if ({o_if_rsp_val, o_if_rdat} !== {1'b1, 32'hCAFE_0300}) begin failures++; $display("[TB] FAIL bp_rsp got=%0h/%0h exp=1/cafe0300", o_if_rsp_val, o_if_rdat); end
    cyc();
    i_mm_rsp_val = 1'b0;
    i_mm_rdat    = 32'h0;
  endtask

  task automatic test_stray_response();
    i_mm_rsp_val = 1'b1;
    i_mm_rdat    = 32'h5151_5151;
    @(negedge clk);
    checks++; if ({o_if_rsp_val, o_ls_rsp_val, hs_bi4mm_val} !== 3'b000) begin failures++; $display("[TB] FAIL stray_idle got=%b exp=000", {o_if_rsp_val, o_ls_rsp_val, hs_bi4mm_val}); end
    cyc();
    i_mm_rsp_val = 1'b0;
    hs_if4bi_val = 1'b1;
    i_if_adr     = 32'h0000_0500;
    hs_mm4bi_rdy = 1'b0;
    @(negedge clk);
    checks++; if (hs_bi4if_rdy !== 1'b1) begin failures++; $display("[TB] FAIL stray_grant got=%0h exp=1", hs_bi4if_rdy); end
    cyc();
    hs_if4bi_val = 1'b0;
    i_mm_rsp_val = 1'b1;
    @(negedge clk);
    checks++; if ({o_if_rsp_val, o_ls_rsp_val} !== 2'b00) begin failures++; $display("[TB] FAIL stray_req_rsp got=%b exp=00", {o_if_rsp_val, o_ls_rsp_val}); end
    cyc();
    i_mm_rsp_val = 1'b0;
    hs_mm4bi_rdy = 1'b1;
    @(negedge clk);
    checks++; if ({hs_bi4mm_val, o_mm_adr} !== {1'b1, 32'h500}) begin failures++; $display("[TB] FAIL stray_still_req got=%0h/%0h exp=1/500", hs_bi4mm_val, o_mm_adr); end
    cyc();
    i_mm_rsp_val = 1'b1;
    i_mm_rdat    = 32'h0000_0505;
    @(negedge clk);
    checks++; if ({o_if_rsp_val, o_if_rdat} !== {1'b1, 32'h0000_0505}) begin failures++; $display("[TB] FAIL stray_final_rsp got=%0h/%0h exp=1/505", o_if_rsp_val, o_if_rdat); end
    cyc();
    i_mm_rsp_val = 1'b0;
    i_mm_rdat    = 32'h0;
  endtask

  task automatic test_reset_mid_wait();
    hs_if4bi_val = 1'b1;
    i_if_adr     = 32'h0000_0400;
    hs_mm4bi_rdy = 1'b1;
    @(negedge clk);
    checks++; if (hs_bi4if_rdy !== 1'b1) begin failures++; $display("[TB] FAIL rstw_grant got=%0h exp=1", hs_bi4if_rdy); end
    cyc();
    hs_if4bi_val = 1'b0;
    cyc();
    hs_if4bi_val = 1'b1;
    hs_ls4bi_val = 1'b1;
    i_ls_adr     = 32'h0000_0600;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({hs_bi4if_rdy, hs_bi4ls_rdy, hs_bi4mm_val, o_if_rsp_val, o_ls_rsp_val} !== 5'b00000) begin failures++; $display("[TB] FAIL rstw_ctrl got=%b exp=00000", {hs_bi4if_rdy, hs_bi4ls_rdy, hs_bi4mm_val, o_if_rsp_val, o_ls_rsp_val}); end
    checks++; if ({o_mm_adr, o_mm_wdat, o_mm_wen, o_mm_ren, o_if_rdat, o_ls_rdat} !== 133'd0) begin failures++; $display("[TB] FAIL rstw_data got=%0h exp=0", {o_mm_adr, o_mm_ren, o_if_rdat, o_ls_rdat}); end
    cyc();
    rst_n        = 1'b1;
    hs_if4bi_val = 1'b0;
    hs_ls4bi_val = 1'b0;
    i_mm_rsp_val = 1'b1;
    i_mm_rdat    = 32'h0000_0BAD;
    @(negedge clk);
    checks++; if ({o_if_rsp_val, o_ls_rsp_val, hs_bi4mm_val} !== 3'b000) begin failures++; $display("[TB] FAIL rstw_late_rsp got=%b exp=000", {o_if_rsp_val, o_ls_rsp_val, hs_bi4mm_val}); end
    cyc();
    i_mm_rsp_val = 1'b0;
    hs_if4bi_val = 1'b1;
    hs_ls4bi_val = 1'b1;
    @(negedge clk);
    checks++; if ({hs_bi4if_rdy, hs_bi4ls_rdy} !== 2'b10) begin failures++; $display("[TB] FAIL rstw_tie got=%b exp=10", {hs_bi4if_rdy, hs_bi4ls_rdy}); end
    cyc();
    hs_if4bi_val = 1'b0;
    hs_ls4bi_val = 1'b0;
    @(negedge clk);
    checks++; if ({hs_bi4mm_val, o_mm_adr} !== {1'b1, 32'h400}) begin failures++; $display("[TB] FAIL rstw_next_req got=%0h/%0h exp=1/400", hs_bi4mm_val, o_mm_adr); end
    cyc();
    i_mm_rsp_val = 1'b1;
    @(negedge clk);
    checks++; if ({o_if_rsp_val, o_ls_rsp_val} !== 2'b10) begin failures++; $display("[TB] FAIL rstw_next_rsp got=%b exp=10", {o_if_rsp_val, o_ls_rsp_val}); end
    cyc();
    i_mm_rsp_val = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_round_robin();
    test_single_fetch();
    test_store();
    test_backpressure();
    test_stray_response();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_biu_arb.md
# exu_biu_arb

Bus-interface arbiter that shares the core's single memory port between the instruction-fetch path and the load/store path of the execute unit. It accepts one request at a time from either requester over a val/rdy handshake, forwards it to memory, tracks the single outstanding transaction and routes the response back to its owner. Ties are resolved round-robin. It sits between the fetch unit, the execute unit's load/store interface and the memory/bus port.

## Interface
- No parameters. Address and data are 32 bits; byte enables are 4 bits.
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- hs_if4bi_val  in  1  fetch request valid (read-only)
- i_if_adr  in  32  fetch address
- hs_bi4if_rdy  out  1  fetch request accepted this cycle
- o_if_rsp_val  out  1  fetch response valid, one-cycle pulse
- o_if_rdat  out  32  fetch read data, valid with o_if_rsp_val, 0 otherwise
- hs_ls4bi_val  in  1  load/store request valid
- i_ls_adr  in  32  load/store address
- i_ls_wdat  in  32  store data
- i_ls_wen  in  4  store byte enables
- i_ls_ren  in  1  load enable
- hs_bi4ls_rdy  out  1  load/store request accepted this cycle
- o_ls_rsp_val  out  1  load/store response valid, one-cycle pulse; also issued for stores
- o_ls_rdat  out  32  load data, valid with o_ls_rsp_val, 0 otherwise
- hs_bi4mm_val  out  1  memory request valid
- hs_mm4bi_rdy  in  1  memory accepts request
- o_mm_adr  out  32  memory address
- o_mm_wdat  out  32  memory write data
- o_mm_wen  out  4  memory byte enables
- o_mm_ren  out  1  memory read enable
- i_mm_rsp_val  in  1  memory response valid
- i_mm_rdat  in  32  memory read data

## Operation
- State machine with three states: IDLE, REQ, WAIT. Also holds an owner register (IF/LS), a last_grant register and latched request fields (adr, wdat, wen, ren).
- IDLE behaviour:
  - If only one requester asserts val, that requester is granted.
  - If both assert val, the requester not recorded in last_grant is granted.
  - On a grant, the granted rdy is asserted combinationally in the same cycle, the request fields are latched, owner and last_grant are set to the winner, and the state moves to REQ.
  - A fetch latches wen=0, ren=1, wdat=0.
- REQ: hs_bi4mm_val=1. o_mm_* are driven from the latched registers and are stable until the handshake. On hs_mm4bi_rdy the state moves to WAIT.
- WAIT: waits for i_mm_rsp_val. In that cycle the owner's rsp_val is 1 and its rdat equals i_mm_rdat, both combinational. The state then moves to IDLE.
- Both requester rdy signals are 0 outside IDLE. Only one transaction is ever outstanding.
- i_mm_rsp_val outside WAIT is ignored. Memory must not respond in the same cycle as the request handshake.
- Requester fields are don't-care except in the accepting cycle. Requesters may hold val across rdy=0 cycles.
- o_mm_* are 0 whenever hs_bi4mm_val=0.

## Timing
- Reset (async, mid-transaction included):
  - state=IDLE, owner=IF, last_grant=LS, latched fields=0.
  - All outputs are 0.
  - Any in-flight memory transaction is abandoned; a late memory response is ignored because the state is IDLE.
- Best-case latency, with memory rdy=1 in its first REQ cycle and response one cycle later:
  - cycle 0: val, with rdy in the same cycle
  - cycle 1: hs_bi4mm_val and handshake
  - cycle 2: i_mm_rsp_val and rsp_val to the owner
  - cycle 3: IDLE, next grant possible
- Back-to-back throughput is one transaction per 3 cycles minimum.
- Memory stall in REQ: val and fields are held indefinitely; no timeout.
- Response stall in WAIT: held indefinitely.
- Both requesters valid continuously: grants alternate IF, LS, IF, ... The first tie after reset goes to IF because last_grant resets to LS.
- A new request arriving in the WAIT-exit cycle is not granted until the following IDLE cycle.

## Test plan
- Single fetch: hs_if4bi_val=1, adr=0x0000_0100, mem rdy=1, response 0xDEAD_BEEF one cycle later:
  - hs_bi4if_rdy in cycle 0
  - hs_bi4mm_val with o_mm_adr=0x100, o_mm_ren=1, wen=0 in cycle 1
  - o_if_rsp_val=1 with o_if_rdat=0xDEAD_BEEF in cycle 2
  - o_ls_rsp_val=0 throughout
- Store: ls val, adr=0x2004, wdat=0x1234_5678, wen=4'b0011, ren=0:
  - o_mm_* match exactly
  - the memory response pulses o_ls_rsp_val, not o_if_rsp_val
- Tie round-robin: both valid continuously from reset for 6 transactions:
  - grant order IF, LS, IF, LS, IF, LS
  - never two rdy signals in one cycle
- Memory backpressure: hs_mm4bi_rdy=0 for 5 cycles during REQ:
  - hs_bi4mm_val stays 1 with constant adr/wdat/wen/ren
  - no requester rdy during the stall
  - the transaction completes after rdy rises
- Stray response: i_mm_rsp_val pulsed in IDLE and REQ:
  - no rsp_val output
  - state is unaffected
- Reset mid-WAIT: assert rst_n=0 while WAIT:
  - all outputs 0 immediately
  - after release, a late i_mm_rsp_val is ignored
  - the next tie is granted to IF
